dyn_reconf_regfile: RTL and testbench

//  Parametrised DRP register file for the PLL/MMCM simulation models.
//  - Holds the model's dynamic-reconfiguration registers in a window of the DRP address space.
//  - Completes each DEN request after a programmable number of DCLK cycles with a one-cycle DRDY pulse.
//  - Flags accesses outside the window with DERR.
//  - Exports all registers flat, plus a CFG_UPDATE strobe, for the PLL core to consume.

---
 rtl/dyn_reconf_regfile.sv | 149 ++++++++++++++
 tb/tb_dyn_reconf_regfile.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dyn_reconf_regfile.sv
// DRP register file for PLL/MMCM models: a window of registers behind a
// DEN/DRDY handshake with programmable completion latency.
module dyn_reconf_regfile #(
    parameter int                    ADDR_WIDTH = 7,
    parameter int                    DATA_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 7'h06,
    parameter int                    NUM_REGS   = 17,
    parameter int                    LATENCY    = 3,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                           DCLK,
    input  logic                           RST,
    input  logic                           PWRDWN,
    input  logic [ADDR_WIDTH-1:0]          DADDR,
    input  logic                           DEN,
    input  logic                           DWE,
    input  logic [DATA_WIDTH-1:0]          DI,
    output logic [DATA_WIDTH-1:0]          DO,
    output logic                           DRDY,
    output logic                           DERR,
    output logic                           DBUSY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] CFG,
    output logic                           CFG_UPDATE
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int AW1 = ADDR_WIDTH + 1;
    // One extra bit so BASE_ADDR+NUM_REGS cannot wrap into the address range.
    localparam logic [ADDR_WIDTH:0] ADDR_LO  = {1'b0, BASE_ADDR};
    localparam logic [ADDR_WIDTH:0] ADDR_HI  = ADDR_LO + AW1'(NUM_REGS);
    localparam logic [3:0]          CNT_INIT = 4'(LATENCY - 1);

    state_t                          state_q, state_d;
    logic [3:0]                      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]           addr_q, addr_d;
    logic                            we_q, we_d;
    logic [DATA_WIDTH-1:0]           wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]           do_q, do_d;
    logic                            drdy_q, drdy_d;
    logic                            derr_q, derr_d;
    logic                            upd_q, upd_d;
    logic [NUM_REGS*DATA_WIDTH-1:0]  cfg_q, cfg_d;

    logic [ADDR_WIDTH:0]             addr_ext;
    logic                            addr_valid;
    logic [DATA_WIDTH-1:0]           rd_data;

    assign addr_ext   = {1'b0, addr_q};
    assign addr_valid = (addr_ext >= ADDR_LO) && (addr_ext < ADDR_HI);

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_ext == ADDR_LO + AW1'(i)) begin
                rd_data = cfg_q[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        do_d    = do_q;
        drdy_d  = 1'b0;
        derr_d  = 1'b0;
        upd_d   = 1'b0;
        cfg_d   = cfg_q;

        unique case (state_q)
            IDLE: begin
                if (DEN && !PWRDWN) begin
                    addr_d  = DADDR;
                    we_d    = DWE;
                    wdata_d = DI;
                    cnt_d   = CNT_INIT;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (PWRDWN) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                    drdy_d  = 1'b1;
                    if (!addr_valid) begin
                        derr_d = 1'b1;
                        do_d   = '0;
                    end else if (we_q) begin
                        do_d  = '0;
                        upd_d = 1'b1;
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (addr_ext == ADDR_LO + AW1'(i)) begin
                                cfg_d[i*DATA_WIDTH +: DATA_WIDTH] = wdata_q;
                            end
                        end
                    end else begin
                        do_d = rd_data;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge DCLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            do_q    <= '0;
            drdy_q  <= 1'b0;
            derr_q  <= 1'b0;
            upd_q   <= 1'b0;
            cfg_q   <= {NUM_REGS{RESET_VAL}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            do_q    <= do_d;
            drdy_q  <= drdy_d;
            derr_q  <= derr_d;
            upd_q   <= upd_d;
            cfg_q   <= cfg_d;
        end
    end

    assign DO         = do_q;
    assign DRDY       = drdy_q;
    assign DERR       = derr_q;
    assign DBUSY      = (state_q == BUSY);
    assign CFG        = cfg_q;
    assign CFG_UPDATE = upd_q;

endmodule

// File: tb/tb_dyn_reconf_regfile.sv
// Directed bench for dyn_reconf_regfile: a LATENCY=3 instance and a minimal
// LATENCY=1 single-register instance, responses checked against a scoreboard.
module tb_dyn_reconf_regfile;

    typedef struct {
        logic [15:0] d;
        logic        err;
        logic        upd;
    } resp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance 0: defaults (BASE 6, 17 regs, LATENCY 3)
    logic         pwrdwn0 = 1'b0, den0 = 1'b0, dwe0 = 1'b0;
    logic [6:0]   daddr0  = '0;
    logic [15:0]  di0     = '0;
    logic [15:0]  do0;
    logic         drdy0, derr0, dbusy0, upd0;
    logic [271:0] cfg0;

    // Instance 1: LATENCY 1, one register at address 0
    logic         pwrdwn1 = 1'b0, den1 = 1'b0, dwe1 = 1'b0;
    logic [6:0]   daddr1  = '0;
    logic [15:0]  di1     = '0;
    logic [15:0]  do1;
    logic         drdy1, derr1, dbusy1, upd1;
    logic [15:0]  cfg1;

    dyn_reconf_regfile u0 (
        .DCLK(clk), .RST(rst), .PWRDWN(pwrdwn0), .DADDR(daddr0), .DEN(den0),
        .DWE(dwe0), .DI(di0), .DO(do0), .DRDY(drdy0), .DERR(derr0),
        .DBUSY(dbusy0), .CFG(cfg0), .CFG_UPDATE(upd0)
    );

    dyn_reconf_regfile #(
        .BASE_ADDR(7'h00), .NUM_REGS(1), .LATENCY(1)
    ) u1 (
        .DCLK(clk), .RST(rst), .PWRDWN(pwrdwn1), .DADDR(daddr1), .DEN(den1),
        .DWE(dwe1), .DI(di1), .DO(do1), .DRDY(drdy1), .DERR(derr1),
        .DBUSY(dbusy1), .CFG(cfg1), .CFG_UPDATE(upd1)
    );

    resp_t       q0[$];
    resp_t       q1[$];
    logic [15:0] m0[17];
    logic [15:0] m1;
    int          n_checks = 0;
    int          n_fails  = 0;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [271:0] model_cfg0();
        logic [271:0] v;
        for (int i = 0; i < 17; i++) v[i*16 +: 16] = m0[i];
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitors: pop one expected response per DRDY pulse.
    always begin
        resp_t r;
        @(posedge clk);
        #1;
        if (drdy0) begin
            if (q0.size() == 0) begin
                check("u0_unexpected_drdy", 1'b1, 1'b0);
            end else begin
                r = q0.pop_front();
                check("u0_do", do0, r.d);
                check("u0_derr", derr0, r.err);
                check("u0_cfg_update", upd0, r.upd);
            end
        end else begin
            check("u0_derr_without_drdy", derr0, 1'b0);
            check("u0_update_without_drdy", upd0, 1'b0);
        end
    end

    always begin
        resp_t r;
        @(posedge clk);
        #1;
        if (drdy1) begin
            if (q1.size() == 0) begin
                check("u1_unexpected_drdy", 1'b1, 1'b0);
            end else begin
                r = q1.pop_front();
                check("u1_do", do1, r.d);
                check("u1_derr", derr1, r.err);
                check("u1_cfg_update", upd1, r.upd);
            end
        end else begin
            check("u1_update_without_drdy", upd1, 1'b0);
        end
    end

    task automatic expect0(input logic [6:0] a, input logic we, input logic [15:0] d);
        resp_t r;
        if (a < 7'h06 || a >= 7'h17) begin
            r = '{d: 16'h0, err: 1'b1, upd: 1'b0};
        end else if (we) begin
            r = '{d: 16'h0, err: 1'b0, upd: 1'b1};
            m0[a - 7'h06] = d;
        end else begin
            r = '{d: m0[a - 7'h06], err: 1'b0, upd: 1'b0};
        end
        q0.push_back(r);
    endtask

    task automatic req0(input logic [6:0] a, input logic we, input logic [15:0] d);
        daddr0 = a;
        dwe0   = we;
        di0    = d;
        den0   = 1'b1;
        tick();
        den0 = 1'b0;
        check("u0_busy_after_accept", dbusy0, 1'b1);
    endtask

    task automatic wait_done0();
        for (int i = 1; i < 3; i++) begin
            tick();
            check("u0_drdy_early", drdy0, 1'b0);
            check("u0_busy_in_flight", dbusy0, 1'b1);
        end
        tick();
        check("u0_drdy_on_time", drdy0, 1'b1);
        check("u0_busy_clear_at_done", dbusy0, 1'b0);
    endtask

    task automatic op0(input logic [6:0] a, input logic we, input logic [15:0] d);
        expect0(a, we, d);
        req0(a, we, d);
        wait_done0();
    endtask

    task automatic op1(input logic [6:0] a, input logic we, input logic [15:0] d);
        resp_t r;
        if (a != 7'h00)  r = '{d: 16'h0, err: 1'b1, upd: 1'b0};
        else if (we)     begin r = '{d: 16'h0, err: 1'b0, upd: 1'b1}; m1 = d; end
        else             r = '{d: m1, err: 1'b0, upd: 1'b0};
        q1.push_back(r);
        daddr1 = a;
        dwe1   = we;
        di1    = d;
        den1   = 1'b1;
        tick();
        den1 = 1'b0;
        check("u1_busy_after_accept", dbusy1, 1'b1);
        tick();
        check("u1_drdy_next_edge", drdy1, 1'b1);
        check("u1_busy_clear", dbusy1, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 17; i++) m0[i] = 16'h0;
        m1 = 16'h0;

        // 1. Reset state
        tick();
        tick();
        check("rst_do", do0, 16'h0);
        check("rst_drdy", drdy0, 1'b0);
        check("rst_dbusy", dbusy0, 1'b0);
        check("rst_cfg", cfg0, 272'h0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_drdy", drdy0, 1'b0);
        end

        // 2. Write then read back
        op0(7'h08, 1'b1, 16'h9999);
        check("cfg_reg2", cfg0[2*16 +: 16], 16'h9999);
        op0(7'h08, 1'b0, 16'h0);

        // Window edges
        op0(7'h06, 1'b1, 16'h1111);
        op0(7'h16, 1'b1, 16'hFEED);
        op0(7'h06, 1'b0, 16'h0);
        op0(7'h16, 1'b0, 16'h0);

        // 3. Out-of-window accesses
        op0(7'h05, 1'b0, 16'h0);
        op0(7'h17, 1'b1, 16'hDEAD);
        op0(7'h7F, 1'b1, 16'hBEEF);
        check("cfg_after_invalid", cfg0, model_cfg0());

        // 4. DEN while busy is ignored; DEN on the DRDY-drop edge is accepted
        expect0(7'h08, 1'b1, 16'h1234);
        req0(7'h08, 1'b1, 16'h1234);
        daddr0 = 7'h06;
        dwe0   = 1'b0;
        den0   = 1'b1;
        tick();
        den0 = 1'b0;
        check("ignored_den_drdy_k1", drdy0, 1'b0);
        tick();
        check("ignored_den_drdy_k2", drdy0, 1'b0);
        tick();
        check("ignored_den_drdy_k3", drdy0, 1'b1);
        op0(7'h08, 1'b0, 16'h0);
        for (int i = 0; i < 4; i++) tick();
        check("cfg_after_b2b", cfg0, model_cfg0());

        // 5a. Reset during an in-flight write
        req0(7'h07, 1'b1, 16'hABCD);
        tick();
        rst = 1'b1;
        #1;
        check("rst_abort_dbusy", dbusy0, 1'b0);
        check("rst_abort_cfg", cfg0, 272'h0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 17; i++) m0[i] = 16'h0;
        m1 = 16'h0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rst_abort_no_drdy", drdy0, 1'b0);
        end
        check("rst_abort_reg1", cfg0[1*16 +: 16], 16'h0);

        // 5b. PWRDWN during an in-flight write, then PWRDWN blocking DEN
        op0(7'h10, 1'b1, 16'h5555);
        req0(7'h07, 1'b1, 16'hABCD);
        pwrdwn0 = 1'b1;
        den0    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("pwrdwn_dbusy", dbusy0, 1'b0);
            check("pwrdwn_no_drdy", drdy0, 1'b0);
        end
        den0    = 1'b0;
        pwrdwn0 = 1'b0;
        tick();
        check("pwrdwn_cfg_retained", cfg0, model_cfg0());
        op0(7'h07, 1'b0, 16'h0);
        op0(7'h10, 1'b0, 16'h0);

        // 6. LATENCY=1, single register at address 0
        op1(7'h00, 1'b1, 16'h5A5A);
        check("u1_cfg", cfg1, 16'h5A5A);
        op1(7'h00, 1'b0, 16'h0);
        op1(7'h01, 1'b0, 16'h0);
        op1(7'h7F, 1'b1, 16'h0F0F);
        op1(7'h00, 1'b0, 16'h0);
        check("u1_cfg_final", cfg1, m1);

        for (int i = 0; i < 3; i++) tick();
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
